mul_issue_scheduler: RTL and testbench

Shares the single Wallace-tree 32x32 multiplier among the multiply reservation stations of the Tomasulo core. It picks one ready station per cycle using round-robin arbitration and registers that station's operands into the combinational multiplier. It then carries product and tag through a fixed-latency pipeline. The result is held in an output buffer until the common data bus (CDB) grants the broadcast.

---
 rtl/mul_issue_scheduler_pkg.sv | 14 +
 rtl/mul_issue_scheduler_rr_arbiter.sv | 33 +++
 rtl/mul_issue_scheduler.sv | 123 ++++++++++++
 tb/tb_mul_issue_scheduler.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_issue_scheduler_pkg.sv
// Shared widths, defaults and the pipeline stage record for the multiply issue scheduler.
package mul_issue_scheduler_pkg;
  localparam int DATA_W     = 32;
  localparam int TAG_W      = 4;
  localparam int PROD_W     = 2 * DATA_W;
  localparam int NUM_RS_DEF = 3;
  localparam int LAT_DEF    = 2;

  typedef struct packed {
    logic              vld;
    logic [TAG_W-1:0]  tag;
    logic [PROD_W-1:0] data;
  } prod_stage_t;
endpackage

// File: rtl/mul_issue_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr_i (wrapping) wins; next pointer follows the winner.
module rr_arbiter #(
  parameter int NUM_RS = 3,
  parameter int PTR_W  = (NUM_RS > 1) ? $clog2(NUM_RS) : 1
) (
  input  logic [NUM_RS-1:0] req_i,
  input  logic              en_i,
  input  logic [PTR_W-1:0]  ptr_i,
  output logic [NUM_RS-1:0] grant_o,
  output logic [PTR_W-1:0]  ptr_next_o
);
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    grant_o    = '0;
    ptr_next_o = ptr_i;
    found      = 1'b0;
    sum        = '0;
    idx        = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      sum = {1'b0, ptr_i} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_RS)) sum = sum - (PTR_W+1)'(NUM_RS);
      idx = sum[PTR_W-1:0];
      if (en_i && !found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
        ptr_next_o   = (idx == PTR_W'(NUM_RS-1)) ? '0 : idx + PTR_W'(1);
      end
    end
  end
endmodule

// File: rtl/mul_issue_scheduler.sv
// Issues one ready multiply per cycle into the shared multiplier and carries product+tag
// through a lock-step pipeline into a CDB output buffer.
module mul_issue_scheduler
  import mul_issue_scheduler_pkg::*;
#(
  parameter int NUM_RS = NUM_RS_DEF,
  parameter int LAT    = LAT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [NUM_RS-1:0]        req,
  input  logic [NUM_RS*DATA_W-1:0] req_a,
  input  logic [NUM_RS*DATA_W-1:0] req_b,
  input  logic [NUM_RS*TAG_W-1:0]  req_tag,
  output logic [NUM_RS-1:0]        grant,
  output logic [DATA_W-1:0]        mul_a,
  output logic [DATA_W-1:0]        mul_b,
  input  logic [PROD_W-1:0]        mul_p,
  output logic                     cdb_req,
  input  logic                     cdb_grant,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [PROD_W-1:0]        cdb_data,
  output logic                     busy
);
  localparam int PTR_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [NUM_RS-1:0] grant_w;
  logic              adv, arb_en;
  logic              s0_vld_q;
  logic [TAG_W-1:0]  s0_tag_q;
  logic [DATA_W-1:0] mul_a_q, mul_b_q;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic [TAG_W-1:0]  sel_tag;
  prod_stage_t       s1_in, tail, obuf_q;
  logic              tail_busy;

  // A full buffer that the CDB is not taking freezes every stage at once.
  assign adv    = !(obuf_q.vld && !cdb_grant);
  assign arb_en = adv && !flush && !reset;

  rr_arbiter #(.NUM_RS(NUM_RS), .PTR_W(PTR_W)) u_arb (
    .req_i      (req),
    .en_i       (arb_en),
    .ptr_i      (ptr_q),
    .grant_o    (grant_w),
    .ptr_next_o (ptr_d)
  );

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_tag = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (grant_w[i]) begin
        sel_a   = req_a[i*DATA_W +: DATA_W];
        sel_b   = req_b[i*DATA_W +: DATA_W];
        sel_tag = req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  assign s1_in = {s0_vld_q, s0_tag_q, mul_p};

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_vld_q <= 1'b0;
      s0_tag_q <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      obuf_q   <= '0;
      ptr_q    <= '0;
    end else if (flush) begin
      s0_vld_q   <= 1'b0;
      obuf_q.vld <= 1'b0;
    end else if (adv) begin
      s0_vld_q <= |grant_w;
      if (|grant_w) begin
        mul_a_q  <= sel_a;
        mul_b_q  <= sel_b;
        s0_tag_q <= sel_tag;
      end
      obuf_q <= tail;
      ptr_q  <= ptr_d;
    end
  end

  generate
    if (LAT == 1) begin : g_direct
      assign tail      = s1_in;
      assign tail_busy = 1'b0;
    end else begin : g_pipe
      prod_stage_t pr_q [LAT-1];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < LAT-1; i++) pr_q[i] <= '0;
        end else if (flush) begin
          for (int i = 0; i < LAT-1; i++) pr_q[i].vld <= 1'b0;
        end else if (adv) begin
          pr_q[0] <= s1_in;
          for (int i = 1; i < LAT-1; i++) pr_q[i] <= pr_q[i-1];
        end
      end

      always_comb begin
        tail_busy = 1'b0;
        for (int i = 0; i < LAT-1; i++) tail_busy = tail_busy | pr_q[i].vld;
      end

      assign tail = pr_q[LAT-2];
    end
  endgenerate

  assign grant    = grant_w;
  assign mul_a    = mul_a_q;
  assign mul_b    = mul_b_q;
  assign cdb_req  = obuf_q.vld && !reset;
  assign cdb_tag  = obuf_q.tag;
  assign cdb_data = obuf_q.data;
  assign busy     = s0_vld_q | tail_busy | obuf_q.vld;
endmodule

// File: tb/tb_mul_issue_scheduler.sv
// Self-checking bench: constant-vector table, directed multi-cycle sequences, and random traffic
// compared against a transaction-level queue model.
module tb_mul_issue_scheduler;
  import mul_issue_scheduler_pkg::*;

  localparam int NRS = 3;
  localparam int L   = 2;

  // clock/reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset, flush, cdb_grant;
  logic [NRS-1:0]        req, grant;
  logic [NRS*DATA_W-1:0] req_a, req_b;
  logic [NRS*TAG_W-1:0]  req_tag;
  logic [DATA_W-1:0]     mul_a, mul_b;
  logic [PROD_W-1:0]     mul_p, cdb_data;
  logic                  cdb_req, busy;
  logic [TAG_W-1:0]      cdb_tag;

  assign mul_p = {{DATA_W{1'b0}}, mul_a} * {{DATA_W{1'b0}}, mul_b};

  mul_issue_scheduler #(.NUM_RS(NRS), .LAT(L)) dut (
    .clk(clk), .reset(reset), .flush(flush), .req(req), .req_a(req_a), .req_b(req_b),
    .req_tag(req_tag), .grant(grant), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .busy(busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // scoreboard / reference model: in-flight results in issue order, each with the number of
  // advancing edges it has seen; a result sits in the CDB buffer once it has seen L+1.
  logic [TAG_W+PROD_W-1:0] exp_q[$];
  int                      age_q[$];
  int                      m_ptr = 0;

  logic [NRS-1:0]    o_grant;
  logic              o_req, o_busy;
  logic [TAG_W-1:0]  o_tag;
  logic [PROD_W-1:0] o_data;
  logic [DATA_W-1:0] o_a, o_b;

  function automatic bit front_ready();
    return exp_q.size() > 0 && age_q[0] == L + 1;
  endfunction

  function automatic int model_pick();
    if (reset || flush) return -1;
    if (front_ready() && !cdb_grant) return -1;
    for (int k = 0; k < NRS; k++) begin
      if (req[(m_ptr + k) % NRS]) return (m_ptr + k) % NRS;
    end
    return -1;
  endfunction

  // driver: one clock cycle; outputs compared mid-cycle, model advanced at the edge
  task automatic cycle();
    int             g;
    bit             fr;
    logic [NRS-1:0] eg;
    @(negedge clk);
    fr = front_ready();
    g  = model_pick();
    eg = (g >= 0) ? NRS'(1 << g) : '0;
    o_grant = grant; o_req = cdb_req; o_busy = busy;
    o_tag = cdb_tag; o_data = cdb_data; o_a = mul_a; o_b = mul_b;
    chk("grant", grant, eg);
    chk("cdb_req", cdb_req, fr && !reset);
    chk("busy", busy, exp_q.size() > 0);
    if (fr && !reset) begin
      chk("cdb_tag", cdb_tag, exp_q[0][PROD_W +: TAG_W]);
      chk("cdb_data", cdb_data, exp_q[0][PROD_W-1:0]);
    end
    @(posedge clk);
    if (reset) begin
      exp_q.delete(); age_q.delete(); m_ptr = 0;
    end else if (flush) begin
      exp_q.delete(); age_q.delete();
    end else if (!(fr && !cdb_grant)) begin
      if (fr) begin
        void'(exp_q.pop_front());
        void'(age_q.pop_front());
      end
      foreach (age_q[i]) age_q[i]++;
      if (g >= 0) begin
        exp_q.push_back({req_tag[g*TAG_W +: TAG_W],
                         64'(req_a[g*DATA_W +: DATA_W]) * 64'(req_b[g*DATA_W +: DATA_W])});
        age_q.push_back(1);
        m_ptr = (g + 1) % NRS;
      end
    end
    #1;
  endtask

  task automatic set_rs(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    req_a[i*DATA_W +: DATA_W] = a;
    req_b[i*DATA_W +: DATA_W] = b;
    req_tag[i*TAG_W +: TAG_W] = t;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [63:0] p;
  } vec_t;

  vec_t           vt[6];
  logic [NRS-1:0] rr_exp[4];
  logic [3:0]     tag_exp[4];
  logic [3:0]     got_tags[$];
  int             first_c, last_c, cyc;

  initial begin
    vt[0] = '{32'd7,        32'd6,        4'd3,  64'd42};
    vt[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 4'd5,  64'hFFFFFFFE00000001};
    vt[2] = '{32'd0,        32'hDEADBEEF, 4'd1,  64'd0};
    vt[3] = '{32'd1,        32'hFFFFFFFF, 4'd15, 64'hFFFFFFFF};
    vt[4] = '{32'h10000,    32'h10000,    4'd9,  64'h100000000};
    vt[5] = '{32'h12345678, 32'h10,       4'd6,  64'h123456780};
    rr_exp  = '{3'b001, 3'b010, 3'b100, 3'b001};
    tag_exp = '{4'd8, 4'd9, 4'd10, 4'd8};

    reset = 1'b1; flush = 1'b0; cdb_grant = 1'b0;
    req = '0; req_a = '0; req_b = '0; req_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    cycle();
    chk("reset_grant", o_grant, 0);
    chk("reset_cdb_req", o_req, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_mul_a", o_a, 0);
    chk("reset_mul_b", o_b, 0);
    chk("reset_cdb_tag", o_tag, 0);
    chk("reset_cdb_data", o_data, 0);
    reset = 1'b0; cdb_grant = 1'b1;

    // single-op vectors, no contention: grant now, result exactly L+1 cycles later
    for (int v = 0; v < 6; v++) begin
      set_rs(v % NRS, vt[v].a, vt[v].b, vt[v].tag);
      req = NRS'(1 << (v % NRS));
      cycle();
      chk("vec_grant", o_grant, 1 << (v % NRS));
      req = '0;
      for (int k = 0; k < L; k++) begin
        cycle();
        chk("vec_early_req", o_req, 0);
      end
      cycle();
      chk("vec_cdb_req", o_req, 1);
      chk("vec_cdb_tag", o_tag, vt[v].tag);
      chk("vec_cdb_data", o_data, vt[v].p);
    end

    // round-robin from a fresh pointer
    reset = 1'b1; cycle(); reset = 1'b0;
    for (int i = 0; i < NRS; i++) set_rs(i, 32'(i + 2), 32'd3, 4'(8 + i));
    req = '1;
    got_tags.delete(); cyc = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 4) req = '0;
      cycle();
      if (k < 4) chk("rr_grant", o_grant, rr_exp[k]);
      if (o_req) begin
        if (got_tags.size() == 0) first_c = k;
        last_c = k;
        got_tags.push_back(o_tag);
      end
    end
    chk("rr_result_count", got_tags.size(), 4);
    chk("rr_back_to_back", last_c - first_c, 3);
    for (int k = 0; k < 4 && k < got_tags.size(); k++) chk("rr_tag_order", got_tags[k], tag_exp[k]);

    // backpressure: pointer is 1, so stations 1,2,0 issue; stall for 5 cycles
    for (int i = 0; i < NRS; i++) set_rs(i, 32'(100 + i), 32'd7, 4'(4 + i));
    cdb_grant = 1'b0; req = '1;
    repeat (3) cycle();
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_grant", o_grant, 0);
      chk("bp_cdb_req", o_req, 1);
      chk("bp_cdb_tag", o_tag, 5);
      chk("bp_cdb_data", o_data, 707);
    end
    cdb_grant = 1'b1; req = '0;
    cycle(); chk("bp_rel0_tag", o_tag, 5); chk("bp_rel0_req", o_req, 1);
    cycle(); chk("bp_rel1_tag", o_tag, 6); chk("bp_rel1_req", o_req, 1);
    cycle(); chk("bp_rel2_tag", o_tag, 4); chk("bp_rel2_req", o_req, 1);
    cycle(); chk("bp_drained", o_req, 0);

    // flush with buffer full and two behind it; pointer 1 -> grants 1,2,0 -> pointer 1 again
    cdb_grant = 1'b0; req = '1;
    repeat (4) cycle();
    flush = 1'b1;
    cycle();
    chk("fl_grant", o_grant, 0);
    flush = 1'b0; req = '0;
    cycle();
    chk("fl_busy", o_busy, 0);
    chk("fl_cdb_req", o_req, 0);
    req = '1; cdb_grant = 1'b1;
    cycle();
    chk("fl_rotation", o_grant, 3'b010);
    req = '0;
    repeat (4) cycle();

    // reset mid-stream, then a lone request from station 2
    req = '1;
    repeat (2) cycle();
    reset = 1'b1; req = '0;
    cycle();
    reset = 1'b0;
    cycle();
    chk("mid_grant", o_grant, 0);
    chk("mid_cdb_req", o_req, 0);
    chk("mid_busy", o_busy, 0);
    chk("mid_mul_a", o_a, 0);
    chk("mid_mul_b", o_b, 0);
    chk("mid_cdb_tag", o_tag, 0);
    chk("mid_cdb_data", o_data, 0);
    set_rs(2, 32'h55, 32'd3, 4'd12);
    req = 3'b100;
    cycle();
    chk("mid_new_grant", o_grant, 3'b100);
    req = '0;
    repeat (L) cycle();
    cycle();
    chk("mid_new_req", o_req, 1);
    chk("mid_new_tag", o_tag, 12);
    chk("mid_new_data", o_data, 64'hFF);

    // random traffic against the model
    for (int n = 0; n < 800; n++) begin
      req = NRS'($urandom_range(0, 7));
      for (int i = 0; i < NRS; i++) set_rs(i, $urandom(), ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom(),
                                        4'($urandom_range(0, 15)));
      cdb_grant = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 39) == 0);
      reset     = ($urandom_range(0, 79) == 0);
      cycle();
    end
    reset = 1'b0; flush = 1'b0; req = '0; cdb_grant = 1'b1;
    repeat (L + 3) cycle();
    chk("final_idle", o_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
